// File: rtl/ula_controlador.sv
// Sequencing controller for the 8-bit ALU: latches a request, waits the op latency
// (one cycle or the mult/div latency), then registers the result and status flags.
module ula_controlador #(
    parameter int LAT_MULT = 8,
    parameter int LAT_DIV  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [2:0] op_sel,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [2:0] ula_sel,
    output logic       seq_inicio,
    input  logic [7:0] ula_resultado,
    output logic       ocupado,
    output logic       pronto,
    output logic [7:0] resultado,
    output logic       flag_zero,
    output logic       flag_neg,
    output logic       flag_div0
);

    localparam int LAT_MAX = (LAT_MULT > LAT_DIV) ? LAT_MULT : LAT_DIV;
    localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;

    typedef enum logic {
        OCIOSO  = 1'b0,
        EXECUTA = 1'b1
    } estado_t;

    estado_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  ula_a_q, ula_a_d;
    logic [7:0]  ula_b_q, ula_b_d;
    logic [2:0]  ula_sel_q, ula_sel_d;
    logic        div0_pend_q, div0_pend_d;
    logic        seq_inicio_q, seq_inicio_d;
    logic        pronto_q, pronto_d;
    logic [7:0]  resultado_q, resultado_d;
    logic        flag_zero_q, flag_zero_d;
    logic        flag_neg_q, flag_neg_d;
    logic        flag_div0_q, flag_div0_d;
    logic [7:0]  cap_val;

    // A division by zero never starts the divider; its result is forced to all ones.
    assign cap_val = div0_pend_q ? 8'hFF : ula_resultado;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_sel_d    = ula_sel_q;
        div0_pend_d  = div0_pend_q;
        seq_inicio_d = 1'b0;
        pronto_d     = 1'b0;
        resultado_d  = resultado_q;
        flag_zero_d  = flag_zero_q;
        flag_neg_d   = flag_neg_q;
        flag_div0_d  = flag_div0_q;

        case (state_q)
            OCIOSO: begin
                if (inicio) begin
                    ula_a_d     = op_a;
                    ula_b_d     = op_b;
                    ula_sel_d   = op_sel;
                    div0_pend_d = (op_sel == OP_DIV) && (op_b == 8'h00);
                    cnt_d       = '0;
                    state_d     = EXECUTA;
                    if (op_sel == OP_MULT) begin
                        cnt_d        = CW'(LAT_MULT - 1);
                        seq_inicio_d = 1'b1;
                    end else if ((op_sel == OP_DIV) && (op_b != 8'h00)) begin
                        cnt_d        = CW'(LAT_DIV - 1);
                        seq_inicio_d = 1'b1;
                    end
                end
            end
            EXECUTA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    resultado_d = cap_val;
                    flag_zero_d = (cap_val == 8'h00);
                    flag_neg_d  = cap_val[7];
                    flag_div0_d = div0_pend_q;
                    pronto_d    = 1'b1;
                    state_d     = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OCIOSO;
            cnt_q        <= '0;
            ula_a_q      <= 8'h00;
            ula_b_q      <= 8'h00;
            ula_sel_q    <= 3'd0;
            div0_pend_q  <= 1'b0;
            seq_inicio_q <= 1'b0;
            pronto_q     <= 1'b0;
            resultado_q  <= 8'h00;
            flag_zero_q  <= 1'b0;
            flag_neg_q   <= 1'b0;
            flag_div0_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_sel_q    <= ula_sel_d;
            div0_pend_q  <= div0_pend_d;
            seq_inicio_q <= seq_inicio_d;
            pronto_q     <= pronto_d;
            resultado_q  <= resultado_d;
            flag_zero_q  <= flag_zero_d;
            flag_neg_q   <= flag_neg_d;
            flag_div0_q  <= flag_div0_d;
        end
    end

    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_sel    = ula_sel_q;
    assign seq_inicio = seq_inicio_q;
    assign ocupado    = (state_q == EXECUTA);
    assign pronto     = pronto_q;
    assign resultado  = resultado_q;
    assign flag_zero  = flag_zero_q;
    assign flag_neg   = flag_neg_q;
    assign flag_div0  = flag_div0_q;

endmodule

// File: tb/tb_ula_controlador.sv
// Bench for ula_controlador: directed requests push expected captures into a queue,
// a negedge monitor pops and checks value, flags and arrival cycle on each pronto.
module tb_ula_controlador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inicio = 1'b0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic [2:0] op_sel = 3'd0;
    logic [7:0] ula_a, ula_b, resultado, ula_resultado;
    logic [2:0] ula_sel;
    logic       seq_inicio, ocupado, pronto, flag_zero, flag_neg, flag_div0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       z, n, d0;
        int         due;
    } exp_t;
    exp_t sb[$];

    ula_controlador #(.LAT_MULT(8), .LAT_DIV(8)) dut (
        .clk(clk), .rst(rst), .inicio(inicio),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel),
        .seq_inicio(seq_inicio), .ula_resultado(ula_resultado),
        .ocupado(ocupado), .pronto(pronto), .resultado(resultado),
        .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_div0(flag_div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; its division-by-zero output is deliberately 00 so a forced FF is visible.
    always_comb begin
        ula_resultado = 8'h00;
        case (ula_sel)
            3'd0: ula_resultado = ula_a + ula_b;
            3'd1: ula_resultado = ula_a - ula_b;
            3'd2: ula_resultado = ula_a * ula_b;
            3'd3: ula_resultado = (ula_b == 8'h00) ? 8'h00 : ula_a / ula_b;
            3'd4: ula_resultado = ula_a & ula_b;
            3'd5: ula_resultado = ula_a | ula_b;
            3'd6: ula_resultado = ula_a ^ ula_b;
            default: ula_resultado = ~ula_a;
        endcase
    end

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (!rst) begin
            if (pronto) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pronto: got pronto at cycle %0d, required none (res=%02h)", cyc, resultado);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (resultado !== e.res || flag_zero !== e.z || flag_neg !== e.n ||
                        flag_div0 !== e.d0 || cyc != e.due) begin
                        fails++;
                        $display("FAIL %s: got res=%02h z=%b n=%b d0=%b cycle=%0d, required res=%02h z=%b n=%b d0=%b cycle=%0d",
                                 e.name, resultado, flag_zero, flag_neg, flag_div0, cyc,
                                 e.res, e.z, e.n, e.d0, e.due);
                    end else begin
                        $display("txn %s: res=%02h z=%b n=%b d0=%b at cycle %0d ok",
                                 e.name, resultado, flag_zero, flag_neg, flag_div0, cyc);
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                fails++;
                $display("FAIL %s_timeout: no pronto by cycle %0d, required at cycle %0d", e.name, cyc, e.due);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end else begin
            $display("chk %s: %0h ok", nm, act);
        end
    endtask

    // Called near a negedge; presents the request, returns #1 after the accept edge.
    task automatic issue(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input bit push, input logic [7:0] er,
                         input logic ez, input logic en, input logic ed, input int lat);
        exp_t e;
        op_a   = a;
        op_b   = b;
        op_sel = s;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        if (push) begin
            e.name = nm; e.res = er; e.z = ez; e.n = en; e.d0 = ed; e.due = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ula_a, ula_b, ula_sel, seq_inicio, ocupado, pronto,
                              resultado, flag_zero, flag_neg, flag_div0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a multiplication.
        issue("mult_aborted", 8'd12, 8'd10, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", {31'h0, ocupado}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {ula_a, ula_b, ula_sel, seq_inicio, ocupado, pronto,
                                    resultado, flag_zero, flag_neg, flag_div0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        issue("soma", 8'h0F, 8'h01, 3'd0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1);
        wait_done();

        // XOR to zero, then NOT issued while pronto is high.
        issue("xor_zero", 8'hA5, 8'hA5, 3'd6, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pronto) break;
        end
        issue("not_b2b", 8'h00, 8'h33, 3'd7, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1);
        wait_done();

        // Multiplication with ignored extra requests while busy.
        issue("mult", 8'd12, 8'd10, 3'd2, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 8);
        @(negedge clk);
        chk("mult_seq_pulse", {31'h0, seq_inicio}, 32'h1);
        chk("mult_busy", {31'h0, ocupado}, 32'h1);
        op_a = 8'hFF; op_b = 8'h01; op_sel = 3'd0; inicio = 1'b1;
        @(negedge clk);
        chk("mult_seq_single", {31'h0, seq_inicio}, 32'h0);
        chk("mult_ops_held", {21'h0, ula_a, ula_sel}, {21'h0, 8'd12, 3'd2});
        @(negedge clk);
        inicio = 1'b0;
        wait_done();

        issue("div0", 8'h20, 8'h00, 3'd3, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1);
        @(negedge clk);
        chk("div0_no_seq", {31'h0, seq_inicio}, 32'h0);
        wait_done();

        issue("div", 8'd100, 8'd7, 3'd3, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0, 8);
        @(negedge clk);
        chk("div_seq_pulse", {31'h0, seq_inicio}, 32'h1);
        wait_done();
        repeat (2) @(negedge clk);
        chk("idle_hold_operands", {13'h0, ula_a, ula_b, ula_sel}, {13'h0, 8'd100, 8'd7, 3'd3});
        chk("result_hold", {24'h0, resultado}, 32'h0E);
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
